lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. Accepts one RV32I load or store per handshake, decodes its funct3 width (LB/LH/LW/LBU/LHU, SB/SH/SW), and drives a word-aligned request/grant/response bus. It generates byte strobes, lane-shifts write data, and sign- or zero-extends load data. One access is in flight at a time; under a build option, accesses that cross a word boundary are split into two bus transactions.

## Interface
- ADDR_W, 32, byte-address width; mem_addr is always word-aligned.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  width/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination tag, echoed on resp_rd.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address, with [1:0] = 0.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  beat complete; also sent for writes.
- mem_rdata  in  32  read data, valid with mem_rvalid.
- mem_err  in  1  bus error, valid with mem_rvalid.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rd  out  5  echoed tag.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  illegal funct3, disallowed misalignment, or bus error.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE -> REQ0 on req_valid. All request fields are latched at this point.
- IDLE -> RESP with resp_err=1 and no bus activity when:
  - a load has funct3 ∈ {3,6,7}, or
  - a store has funct3 ≥ 3, or
  - the access is misaligned and misalignment is not allowed (see Configuration).
- Lane computation:
  - off = addr[1:0].
  - mask = 4'b0001 (B), 4'b0011 (H), 4'b1111 (W).
  - strb8 = mask << off (8 bits).
  - data64 = {32'b0, wdata} << (8*off).
  - Beat 0 uses address addr&~3, strb8[3:0], data64[31:0].
  - Beat 1 uses address (addr&~3)+4 (wraps modulo 2^ADDR_W), strb8[7:4], data64[63:32].
  - A second beat is needed iff strb8[7:4] != 0.
- REQ0 -> WAIT0 on mem_gnt. WAIT0 on mem_rvalid goes:
  - to REQ1 if a second beat is needed and mem_err=0;
  - otherwise to RESP.
- REQ1 -> WAIT1 on mem_gnt. WAIT1 -> RESP on mem_rvalid.
- Load assembly:
  - raw64 = {beat1 rdata, beat0 rdata}; beat1 is 0 if not fetched.
  - r = raw64 >> (8*off).
  - LB/LH sign-extend r[7:0]/r[15:0]; LBU/LHU zero-extend; LW uses r[31:0].
- In RESP: resp_valid=1 for one cycle, then IDLE. resp_err = OR of mem_err over all completed beats.
- mem_rvalid is ignored in IDLE, REQ0 and REQ1.

## Timing
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after release.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
  - resp_valid=0, resp_rd=0, resp_rdata=0, resp_err=0.
  - State = IDLE.
- Accept in cycle T. mem_req is high from T+1 and stays stable (all mem_* outputs unchanged) until mem_gnt.
- Best case, single beat (gnt at T+1, rvalid at T+2): resp_valid at T+3.
- Best case, two beats: resp_valid at T+5.
- Error without bus activity: resp_valid at T+1.
- Earliest next accept is the cycle after resp_valid. req_ready is never high while resp_valid is high.
- mem_rvalid in the same cycle as mem_gnt is illegal for the bus and is not handled.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and all outputs take reset values. Any late mem_rvalid after release is ignored.

## Configuration
- LSU_MISALIGN_EN:
  - Defined: any alignment is allowed. Accesses inside one word use one beat; word-crossing accesses use two beats (beat 0 first).
  - Undefined: an access is misaligned when H has addr[0]≠0 or W has addr[1:0]≠0. A misaligned access returns resp_err=1 at T+1 and issues no bus request. The REQ1 and WAIT1 states are not synthesized.

## Test plan
- LW at 0x100, rdata 0xDEADBEEF, gnt and rvalid with no stalls -> mem_addr=0x100, wstrb=0; resp_rdata=0xDEADBEEF at T+3.
- SB wdata=0x000000A5 at 0x203 -> mem_addr=0x200, wstrb=4'b1000, mem_wdata=0xA5000000, mem_we=1; resp_rdata=0.
- LB at 0x102 with rdata 0x00800000 -> resp_rdata=0xFFFFFF80. Same access as LBU -> resp_rdata=0x00000080.
- With LSU_MISALIGN_EN, SW 0x11223344 at 0x3FE:
  - beat 0: 0x3FC, wstrb 1100, wdata 0x33440000;
  - beat 1: 0x400, wstrb 0011, wdata 0x00001122;
  - resp at T+5.
  - Without the macro: resp_err=1 at T+1 and mem_req never asserts.
- Load with funct3=3 -> resp_err=1 at T+1, no bus request. Load with mem_err=1 on rvalid -> resp_err=1.
- mem_gnt withheld 5 cycles -> mem_* outputs stable throughout. rst_n pulsed in WAIT0 -> all outputs return to reset values, and a later stray mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: decodes width, drives a word-aligned req/gnt/rvalid bus, extends load data.
// Build option LSU_MISALIGN_EN: allow any alignment, splitting word-crossing accesses into two beats.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state, state_nxt;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata0_q;
  logic              err_q;

  logic              illegal_f3, misaligned, acc_err;
  logic [1:0]        off_q;
  logic [3:0]        mask;
  logic [3:0]        strb0;
  logic [31:0]       data0;
  logic              need_beat1;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       r;
  logic [31:0]       load_ext;

  // Request decode happens on the live inputs so errors can be answered without bus activity.
  always_comb begin
    if (req_store) illegal_f3 = (req_funct3 >= 3'd3);
    else           illegal_f3 = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
`ifdef LSU_MISALIGN_EN
    misaligned = 1'b0;
`else
    misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`endif
    acc_err = illegal_f3 || misaligned;
  end

  assign off_q     = addr_q[1:0];
  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    case (f3_q[1:0])
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  logic [7:0]        strb8;
  logic [63:0]       data64;
  logic [31:0]       rdata1_q;
  logic [63:0]       raw64;

  assign strb8      = {4'b0000, mask} << off_q;
  assign data64     = {32'b0, wdata_q} << {off_q, 3'b000};
  assign strb0      = strb8[3:0];
  assign data0      = data64[31:0];
  assign need_beat1 = |strb8[7:4];
  assign raw64      = {rdata1_q, rdata0_q};
  assign r          = 32'(raw64 >> {off_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   rdata1_q <= '0;
    else if (state == IDLE && req_valid)          rdata1_q <= '0;
    else if (state == WAIT1 && mem_rvalid)        rdata1_q <= mem_rdata;
  end
`else
  assign strb0      = mask << off_q;
  assign data0      = wdata_q << {off_q, 3'b000};
  assign need_beat1 = 1'b0;
  assign r          = rdata0_q >> {off_q, 3'b000};
`endif

  always_comb begin
    case (f3_q)
      3'd0:    load_ext = {{24{r[7]}}, r[7:0]};
      3'd1:    load_ext = {{16{r[15]}}, r[15:0]};
      3'd4:    load_ext = {24'b0, r[7:0]};
      3'd5:    load_ext = {16'b0, r[15:0]};
      default: load_ext = r;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = acc_err ? RESP : REQ0;
      REQ0:  if (mem_gnt) state_nxt = WAIT0;
      WAIT0: if (mem_rvalid) state_nxt = (need_beat1 && !mem_err) ? REQ1 : RESP;
`ifdef LSU_MISALIGN_EN
      REQ1:  if (mem_gnt) state_nxt = WAIT1;
      WAIT1: if (mem_rvalid) state_nxt = RESP;
`endif
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rdata0_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        store_q  <= req_store;
        f3_q     <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        rdata0_q <= '0;
        err_q    <= acc_err;
      end
      if (state == WAIT0 && mem_rvalid) begin
        rdata0_q <= mem_rdata;
        err_q    <= err_q | mem_err;
      end
`ifdef LSU_MISALIGN_EN
      if (state == WAIT1 && mem_rvalid) err_q <= err_q | mem_err;
`endif
    end
  end

  assign req_ready = (state == IDLE) && rst_n;

  // Bus outputs are pure functions of state and latched fields, so they hold steady until grant.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rd    = '0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state)
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = base_addr;
        mem_wstrb = store_q ? strb0 : 4'b0000;
        mem_wdata = store_q ? data0 : 32'b0;
      end
`ifdef LSU_MISALIGN_EN
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = base_addr + ADDR_W'(4);
        mem_wstrb = store_q ? strb8[7:4] : 4'b0000;
        mem_wdata = store_q ? data64[63:32] : 32'b0;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_err   = err_q;
        resp_rdata = store_q ? 32'b0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; the two-beat case is exercised when LSU_MISALIGN_EN is defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns in cycle T+1.
  task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Called in a REQ cycle: holds off grant for 'stall' cycles, then completes the beat.
  task automatic beat(input int stall, input logic [31:0] rdata, input logic err,
                      input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew,
                      input logic ewe);
    for (int i = 0; i <= stall; i++) begin
      check("mem_req", {31'b0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, ea);
      check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, es});
      check("mem_wdata", mem_wdata, ew);
      check("mem_we", {31'b0, mem_we}, {31'b0, ewe});
      if (i == stall) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    check("mem_req_wait", {31'b0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  // Called in the RESP cycle; leaves the DUT back in IDLE.
  task automatic resp(input logic [31:0] edata, input logic chk_data, input logic eerr,
                      input logic [4:0] erd);
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_err", {31'b0, resp_err}, {31'b0, eerr});
    check("resp_rd", {27'b0, resp_rd}, {27'b0, erd});
    check("ready_during_resp", {31'b0, req_ready}, 32'd0);
    if (chk_data) check("resp_rdata", resp_rdata, edata);
    step();
    check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic err_nobus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd);
    accept(st, f3, a, 32'h1234_5678, rd);
    check("no_mem_req", {31'b0, mem_req}, 32'd0);
    resp(32'h0, 1'b0, 1'b1, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    step(); step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // LW at 0x100, no stalls, response at T+3
    accept(1'b0, 3'd2, 32'h100, 32'h0, 5'd3);
    beat(0, 32'hDEAD_BEEF, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp(32'hDEAD_BEEF, 1'b1, 1'b0, 5'd3);

    // SB at 0x203
    accept(1'b1, 3'd0, 32'h203, 32'h0000_00A5, 5'd4);
    beat(0, 32'hFFFF_FFFF, 1'b0, 32'h200, 4'b1000, 32'hA500_0000, 1'b1);
    resp(32'h0, 1'b1, 1'b0, 5'd4);

    // LB / LBU at 0x102
    accept(1'b0, 3'd0, 32'h102, 32'h0, 5'd5);
    beat(0, 32'h0080_0000, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp(32'hFFFF_FF80, 1'b1, 1'b0, 5'd5);
    accept(1'b0, 3'd4, 32'h102, 32'h0, 5'd6);
    beat(0, 32'h0080_0000, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp(32'h0000_0080, 1'b1, 1'b0, 5'd6);

    // LH / LHU at 0x102, grant withheld 5 cycles on the first
    accept(1'b0, 3'd1, 32'h102, 32'h0, 5'd7);
    beat(5, 32'h8001_0000, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp(32'hFFFF_8001, 1'b1, 1'b0, 5'd7);
    accept(1'b0, 3'd5, 32'h102, 32'h0, 5'd8);
    beat(0, 32'h8001_0000, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp(32'h0000_8001, 1'b1, 1'b0, 5'd8);

    // SH at 0x102, grant stalled
    accept(1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 5'd9);
    beat(3, 32'h0, 1'b0, 32'h100, 4'b1100, 32'hBEEF_0000, 1'b1);
    resp(32'h0, 1'b1, 1'b0, 5'd9);

    // Word-crossing SW at 0x3FE; misaligned LH/LW at odd addresses
`ifdef LSU_MISALIGN_EN
    accept(1'b1, 3'd2, 32'h3FE, 32'h1122_3344, 5'd10);
    beat(0, 32'h0, 1'b0, 32'h3FC, 4'b1100, 32'h3344_0000, 1'b1);
    beat(0, 32'h0, 1'b0, 32'h400, 4'b0011, 32'h0000_1122, 1'b1);
    resp(32'h0, 1'b1, 1'b0, 5'd10);
    accept(1'b0, 3'd2, 32'h101, 32'h0, 5'd11);
    beat(0, 32'h4433_2211, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    beat(0, 32'h8877_6655, 1'b0, 32'h104, 4'b0000, 32'h0, 1'b0);
    resp(32'h5544_3322, 1'b1, 1'b0, 5'd11);
`else
    err_nobus(1'b1, 3'd2, 32'h3FE, 5'd10);
    err_nobus(1'b0, 3'd1, 32'h101, 5'd11);
`endif

    // Illegal funct3 codes
    err_nobus(1'b0, 3'd3, 32'h100, 5'd12);
    err_nobus(1'b0, 3'd7, 32'h100, 5'd13);
    err_nobus(1'b1, 3'd4, 32'h100, 5'd14);

    // Bus error on a load
    accept(1'b0, 3'd2, 32'h200, 32'h0, 5'd15);
    beat(0, 32'h0, 1'b1, 32'h200, 4'b0000, 32'h0, 1'b0);
    resp(32'h0, 1'b0, 1'b1, 5'd15);

    // Reset pulsed in WAIT0, then a stray rvalid after release
    accept(1'b1, 3'd2, 32'h300, 32'hCAFE_F00D, 5'd16);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("stray_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("stray_mem_req", {31'b0, mem_req}, 32'd0);
    step();
    check("stray_resp_valid2", {31'b0, resp_valid}, 32'd0);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
